// File: rtl/hist_ram_pipe.sv
// Weighted, saturating histogram held in an inferred RAM: a 3-stage read-modify-write
// pipeline with write forwarding, a drain-then-clear sweep and an arbitrated host port.
module hist_ram_pipe #(
    parameter int BIN_W = 5,
    parameter int CNT_W = 32,
    parameter int WGT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_bin,
    input  logic [WGT_W-1:0] in_weight,
    input  logic             clr_start,
    output logic             busy,
    input  logic             host_req,
    input  logic             host_wr,
    input  logic [BIN_W-1:0] host_addr,
    input  logic [CNT_W-1:0] host_wdata,
    output logic             host_ready,
    output logic             host_rvalid,
    output logic [CNT_W-1:0] host_rdata,
    output logic             sat_flag
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Returns {overflow, result}; on overflow the result is clamped to all-ones.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [WGT_W-1:0] wgt);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + (CNT_W+1)'(wgt);
        if (sum[CNT_W]) begin
            sat_add = {1'b1, {CNT_W{1'b1}}};
        end else begin
            sat_add = sum;
        end
    endfunction

    logic [CNT_W-1:0] mem_q [2**BIN_W];
    logic [CNT_W-1:0] ram_q;

    state_e           state_q, state_d;
    logic [BIN_W-1:0] clr_addr_q, clr_addr_d;
    logic             b_valid_q, b_valid_d, w_valid_q, w_valid_d;
    logic [BIN_W-1:0] b_bin_q, b_bin_d, w_bin_q, w_bin_d;
    logic [WGT_W-1:0] b_wgt_q, b_wgt_d, w_wgt_q, w_wgt_d;
    logic [CNT_W-1:0] w_base_q, w_base_d;
    logic             lw_valid_q, lw_valid_d;
    logic [BIN_W-1:0] lw_addr_q, lw_addr_d;
    logic [CNT_W-1:0] lw_data_q, lw_data_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rvalid_q, rvalid_d;
    logic [CNT_W-1:0] rdata_q, rdata_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             sat_q, sat_d;
    logic             alive_q;

    logic             samp_acc_s, host_ready_s, host_rd_acc_s, host_wr_acc_s;
    logic             ram_we_s;
    logic [BIN_W-1:0] ram_waddr_s, ram_raddr_s;
    logic [CNT_W-1:0] ram_wdata_s, b_base_s, w_fwd_s;
    logic [CNT_W:0]   w_res_s;

    // Handshakes: a present sample always wins over the host.
    always_comb begin
        samp_acc_s    = in_valid && in_ready_q;
        host_ready_s  = alive_q && in_ready_q && !in_valid && !b_valid_q && !w_valid_q;
        host_rd_acc_s = host_req && host_ready_s && !host_wr;
        host_wr_acc_s = host_req && host_ready_s && host_wr;
    end

    // Sweep controller: drain the pipeline, then zero every bin.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) state_d = ST_DRAIN;
                else           state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!b_valid_q) state_d = ST_CLEAR;
                else            state_d = ST_DRAIN;
            end
            ST_CLEAR: begin
                if (clr_addr_q == '1) state_d = ST_IDLE;
                else                  state_d = ST_CLEAR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Forwarding: write from one cycle ago beats the B-stage value, which already
    // folded in the write from two cycles ago over the RAM read.
    always_comb begin
        if (lw_valid_q && (lw_addr_q == b_bin_q)) b_base_s = lw_data_q;
        else                                       b_base_s = ram_q;
        if (lw_valid_q && (lw_addr_q == w_bin_q)) w_fwd_s = lw_data_q;
        else                                       w_fwd_s = w_base_q;
        w_res_s = sat_add(w_fwd_s, w_wgt_q);
    end

    // Single RAM write port: sweep, pipeline and host writers never overlap.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = '0;
        ram_wdata_s = '0;
        if (state_q == ST_CLEAR) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = clr_addr_q;
        end else if (w_valid_q) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = w_bin_q;
            ram_wdata_s = w_res_s[CNT_W-1:0];
        end else if (host_wr_acc_s) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = host_addr;
            ram_wdata_s = host_wdata;
        end else begin
            ram_we_s    = 1'b0;
        end
        if (host_rd_acc_s) ram_raddr_s = host_addr;
        else               ram_raddr_s = in_bin;
    end

    // Next-state for pipeline registers and outputs.
    always_comb begin
        b_valid_d  = samp_acc_s;
        b_bin_d    = b_bin_q;
        b_wgt_d    = b_wgt_q;
        if (samp_acc_s) begin
            b_bin_d = in_bin;
            b_wgt_d = in_weight;
        end else begin
            b_bin_d = b_bin_q;
        end
        w_valid_d  = b_valid_q;
        w_bin_d    = b_bin_q;
        w_wgt_d    = b_wgt_q;
        w_base_d   = b_base_s;
        lw_valid_d = ram_we_s;
        lw_addr_d  = ram_waddr_s;
        lw_data_d  = ram_wdata_s;
        rd_pend_d  = host_rd_acc_s;
        rvalid_d   = rd_pend_q;
        if (rd_pend_q) rdata_d = ram_q;
        else           rdata_d = '0;
        in_ready_d = (state_d == ST_IDLE) && !host_rd_acc_s;
        busy_d     = (state_d == ST_CLEAR);
        if (state_q == ST_CLEAR) clr_addr_d = clr_addr_q + BIN_W'(1);
        else                     clr_addr_d = '0;
        if ((state_d == ST_CLEAR) && (state_q != ST_CLEAR)) sat_d = 1'b0;
        else if (w_valid_q && w_res_s[CNT_W])               sat_d = 1'b1;
        else                                                 sat_d = sat_q;
    end

    // Inferred RAM: registered read returns pre-write data on an address collision.
    always_ff @(posedge clk) begin
        if (ram_we_s) mem_q[ram_waddr_s] <= ram_wdata_s;
        ram_q <= mem_q[ram_raddr_s];
    end

    // Control and pipeline state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            b_valid_q  <= 1'b0;
            b_bin_q    <= '0;
            b_wgt_q    <= '0;
            w_valid_q  <= 1'b0;
            w_bin_q    <= '0;
            w_wgt_q    <= '0;
            w_base_q   <= '0;
            lw_valid_q <= 1'b0;
            lw_addr_q  <= '0;
            lw_data_q  <= '0;
            rd_pend_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            sat_q      <= 1'b0;
            alive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            b_valid_q  <= b_valid_d;
            b_bin_q    <= b_bin_d;
            b_wgt_q    <= b_wgt_d;
            w_valid_q  <= w_valid_d;
            w_bin_q    <= w_bin_d;
            w_wgt_q    <= w_wgt_d;
            w_base_q   <= w_base_d;
            lw_valid_q <= lw_valid_d;
            lw_addr_q  <= lw_addr_d;
            lw_data_q  <= lw_data_d;
            rd_pend_q  <= rd_pend_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            sat_q      <= sat_d;
            alive_q    <= 1'b1;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign host_ready  = host_ready_s;
    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;
    assign sat_flag    = sat_q;
endmodule

// File: tb/tb_hist_ram_pipe.sv
// Directed plus randomized bench for hist_ram_pipe (8-bit counters, 16 bins) against a
// bin-array reference model with saturating sums.
module tb_hist_ram_pipe;
    localparam int BIN_W = 4;
    localparam int CNT_W = 8;
    localparam int WGT_W = 4;
    localparam int NB    = 16;
    localparam int MAXC  = 255;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, clr_start, busy;
    logic [BIN_W-1:0] in_bin, host_addr;
    logic [WGT_W-1:0] in_weight;
    logic             host_req, host_wr, host_ready, host_rvalid, sat_flag;
    logic [CNT_W-1:0] host_wdata, host_rdata;

    int  checks = 0;
    int  errors = 0;
    int  ready_miss = 0;
    int  model [NB];
    int  msat = 0;
    logic [31:0] d;

    hist_ram_pipe #(.BIN_W(BIN_W), .CNT_W(CNT_W), .WGT_W(WGT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin), .in_weight(in_weight),
        .clr_start(clr_start), .busy(busy),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_add(input int b, input int w);
        int t;
        t = model[b] + w;
        if (t > MAXC) begin
            model[b] = MAXC;
            msat = 1;
        end else begin
            model[b] = t;
        end
    endtask

    task automatic drive_sample(input int b, input int w);
        in_valid  = 1'b1;
        in_bin    = b[BIN_W-1:0];
        in_weight = w[WGT_W-1:0];
        @(negedge clk);
        if (in_ready !== 1'b1) ready_miss++;
        @(posedge clk); #1;
        model_add(b, w);
    endtask

    task automatic host_read(input int addr, input string tag, output logic [31:0] data);
        int n;
        n = 0;
        host_req = 1'b1; host_wr = 1'b0; host_addr = addr[BIN_W-1:0];
        @(negedge clk);
        while (host_ready !== 1'b1 && n < 20) begin n++; @(negedge clk); end
        check({tag, "_accept"}, 32'(host_ready), 32'd1);
        @(posedge clk); #1; host_req = 1'b0;
        @(negedge clk);
        check({tag, "_rvalid_early"}, 32'(host_rvalid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_rvalid"}, 32'(host_rvalid), 32'd1);
        data = 32'(host_rdata);
        check({tag, "_data"}, data, 32'(model[addr]));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_rdata_idle"}, 32'(host_rdata), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic host_write(input int addr, input int val, input string tag);
        int n;
        n = 0;
        host_req = 1'b1; host_wr = 1'b1; host_addr = addr[BIN_W-1:0];
        host_wdata = val[CNT_W-1:0];
        @(negedge clk);
        while (host_ready !== 1'b1 && n < 20) begin n++; @(negedge clk); end
        check({tag, "_accept"}, 32'(host_ready), 32'd1);
        @(posedge clk); #1; host_req = 1'b0; host_wr = 1'b0;
        model[addr] = val & MAXC;
        @(negedge clk);
        check({tag, "_no_rvalid"}, 32'(host_rvalid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_clear(input string tag);
        int n, bcnt, rbad;
        n = 0; bcnt = 0; rbad = 0;
        clr_start = 1'b1;
        @(posedge clk); #1; clr_start = 1'b0;
        @(negedge clk);
        while (busy !== 1'b1 && n < 8) begin
            if (in_ready !== 1'b0) rbad++;
            n++; @(negedge clk);
        end
        while (busy === 1'b1 && bcnt < 64) begin
            if (in_ready !== 1'b0) rbad++;
            bcnt++; @(negedge clk);
        end
        check({tag, "_busy_len"}, 32'(bcnt), 32'(NB));
        check({tag, "_ready_low"}, 32'(rbad), 32'd0);
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < NB; i++) model[i] = 0;
        msat = 0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_bin = '0; in_weight = '0; clr_start = 1'b0;
        host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
        for (int i = 0; i < NB; i++) model[i] = 0;

        // Reset values, then release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rvalid", 32'(host_rvalid), 32'd0);
        check("rst_rdata", 32'(host_rdata), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        check("rst_host_ready", 32'(host_ready), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        do_clear("init");

        // Five back-to-back hits on bin 3
        for (int i = 0; i < 5; i++) drive_sample(3, 1);
        in_valid = 1'b0;
        host_read(3, "t1_bin3", d);
        check("t1_bin3_is5", d, 32'd5);

        // Both forwarding distances
        drive_sample(7, 1); drive_sample(7, 2); drive_sample(2, 3); drive_sample(7, 4);
        in_valid = 1'b0;
        host_read(7, "t2_bin7", d);
        check("t2_bin7_is7", d, 32'd7);
        host_read(2, "t2_bin2", d);
        check("t2_bin2_is3", d, 32'd3);

        // Sample and host request in the same cycle
        host_req = 1'b1; host_wr = 1'b0; host_addr = 4'd5;
        in_valid = 1'b1; in_bin = 4'd5; in_weight = 4'd9;
        @(negedge clk);
        check("arb_host_ready", 32'(host_ready), 32'd0);
        check("arb_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1; in_valid = 1'b0; model_add(5, 9);
        @(negedge clk); check("arb_hr_c1", 32'(host_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check("arb_hr_c2", 32'(host_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check("arb_hr_c3", 32'(host_ready), 32'd1);
        @(posedge clk); #1; host_req = 1'b0;
        @(negedge clk); check("arb_rvalid_early", 32'(host_rvalid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("arb_rvalid", 32'(host_rvalid), 32'd1);
        check("arb_rdata", 32'(host_rdata), 32'd9);
        @(posedge clk); #1;

        // Randomized traffic, biased towards a few bins to stress forwarding
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) != 0) begin
                int b;
                if ($urandom_range(0, 1) == 1) b = int'($urandom_range(0, 2));
                else                           b = int'($urandom_range(0, NB-1));
                drive_sample(b, int'($urandom_range(0, 15)));
            end else begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < NB; i++) host_read(i, "rnd", d);
        check("rnd_sat", 32'(sat_flag), 32'(msat));
        do_clear("rnd_clr");

        // Saturation with 8-bit counters, then clear
        host_write(0, 250, "t3_wr");
        for (int i = 0; i < 3; i++) drive_sample(0, 4);
        in_valid = 1'b0;
        host_read(0, "t3_bin0", d);
        check("t3_bin0_is255", d, 32'd255);
        check("t3_sat_set", 32'(sat_flag), 32'd1);
        do_clear("t3_clr");
        host_read(0, "t3_bin0_clr", d);
        check("t3_bin0_is0", d, 32'd0);
        check("t3_sat_clr", 32'(sat_flag), 32'd0);

        // Clear issued with two samples in flight
        drive_sample(9, 5); drive_sample(9, 6);
        in_valid = 1'b0;
        do_clear("t4_clr");
        for (int i = 0; i < NB; i++) host_read(i, "t4_zero", d);

        // Async reset in the middle of a sweep
        clr_start = 1'b1;
        @(posedge clk); #1; clr_start = 1'b0;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (busy !== 1'b1 && n < 8) begin n++; @(negedge clk); end
        end
        check("t6_busy_seen", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy_rst", 32'(busy), 32'd0);
        check("t6_rvalid_rst", 32'(host_rvalid), 32'd0);
        check("t6_rdata_rst", 32'(host_rdata), 32'd0);
        check("t6_sat_rst", 32'(sat_flag), 32'd0);
        check("t6_hready_rst", 32'(host_ready), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("t6_in_ready_rel", 32'(in_ready), 32'd1);
        check("t6_busy_rel", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_busy_stays0", 32'(busy), 32'd0);
        @(posedge clk); #1;
        do_clear("t6_clr");
        drive_sample(1, 11);
        in_valid = 1'b0;
        host_read(1, "t6_after", d);

        check("in_ready_miss", 32'(ready_miss), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
